// File: rtl/multicycle_control_pkg.sv
// Purpose: shared encodings for the multi-cycle sequencer (states, opcodes, ALU codes, classes).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Ports: none.
package multicycle_control_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  // Opcodes, Instr[31:26].
  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_B     = 6'b111111;

  // ALU operation codes.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  // Instruction classes; each class has its own path through the FSM.
  typedef enum logic [2:0] {
    CLS_ALU = 3'd0,   // R-type and immediate ops: EXEC -> WB
    CLS_LW  = 3'd1,   // EXEC -> MEM -> WB
    CLS_SW  = 3'd2,   // EXEC -> MEM -> FETCH
    CLS_BEQ = 3'd3,   // branches resolve and retire in EXEC
    CLS_BNE = 3'd4,
    CLS_B   = 3'd5
  } iclass_e;

  // Branch resolution from class and the ALU zero flag (valid in S_EXEC).
  function automatic logic branch_taken(input iclass_e cls, input logic zero);
    logic taken;
    taken = 1'b0;
    case (cls)
      CLS_B:   taken = 1'b1;
      CLS_BEQ: taken = zero;
      CLS_BNE: taken = ~zero;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Purpose: combinational opcode/func decode into class, ALU function and operand selects.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: opcode_i/func_i in; iclass_o, alu_func_o, alu_bin_sel_o, rf_b_sel_o, illegal_o out.
module control_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [3:0] func_i,
  output iclass_e    iclass_o,
  output logic [3:0] alu_func_o,
  output logic       alu_bin_sel_o,
  output logic       rf_b_sel_o,
  output logic       illegal_o
);

  always_comb begin
    iclass_o      = CLS_ALU;
    alu_func_o    = ALU_ADD;
    alu_bin_sel_o = 1'b0;
    rf_b_sel_o    = 1'b0;
    illegal_o     = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        alu_func_o = func_i;
      end
      OP_ADDI: begin
        alu_func_o    = ALU_ADD;
        alu_bin_sel_o = 1'b1;
      end
      OP_ANDI: begin
        alu_func_o    = ALU_AND;
        alu_bin_sel_o = 1'b1;
      end
      OP_ORI: begin
        alu_func_o    = ALU_OR;
        alu_bin_sel_o = 1'b1;
      end
      OP_LW: begin
        iclass_o      = CLS_LW;
        alu_bin_sel_o = 1'b1;
      end
      OP_SW: begin
        // Store data comes from the rt field, so B reads Instr[20:16].
        iclass_o      = CLS_SW;
        alu_bin_sel_o = 1'b1;
        rf_b_sel_o    = 1'b1;
      end
      OP_BEQ: begin
        iclass_o   = CLS_BEQ;
        alu_func_o = ALU_SUB;
        rf_b_sel_o = 1'b1;
      end
      OP_BNE: begin
        iclass_o   = CLS_BNE;
        alu_func_o = ALU_SUB;
        rf_b_sel_o = 1'b1;
      end
      OP_B: begin
        iclass_o   = CLS_B;
        alu_func_o = ALU_SUB;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Purpose: multi-cycle FSM sequencer driving every datapath strobe, with a timed-out mem handshake.
// Latency: ALU 4, branch 3, sw 4+w, lw 5+w cycles (w = Mem_Ack wait cycles).
// Backpressure: S_MEM holds until Mem_Ack or MEM_TIMEOUT cycles elapse, then aborts with Mem_Err.
// Ports: Clk, Reset (sync, active-high), Instr, Zero, Mem_Ack in; PC/IR/RF/ALU/memory strobes,
//        Illegal and Mem_Err pulses, and the Retired instruction count out.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,   // 1..255
  parameter int unsigned CNT_W       = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      Instr,
  input  logic             Zero,
  input  logic             Mem_Ack,
  output logic             PC_Sel,
  output logic             PC_LdEn,
  output logic             IR_LdEn,
  output logic             RF_WrEn,
  output logic             RF_WrData_sel,
  output logic             RF_B_sel,
  output logic             ALU_Bin_sel,
  output logic [3:0]       ALU_func,
  output logic             Mem_Req,
  output logic             Mem_WrEn,
  output logic             Illegal,
  output logic             Mem_Err,
  output logic [CNT_W-1:0] Retired
);

  // Last counter value tolerated in S_MEM before the access is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       tmo_q, tmo_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  logic             mem_err_q, mem_err_d;
  logic             retire;

  iclass_e    dec_cls;
  logic [3:0] dec_alu_func;
  logic       dec_alu_bin_sel;
  logic       dec_rf_b_sel;
  logic       dec_illegal;

  // Only opcode and the low func nibble select anything; the rest of the IR feeds the datapath.
  logic unused_instr;
  assign unused_instr = ^Instr[25:4];

  control_decode u_decode (
    .opcode_i      (Instr[31:26]),
    .func_i        (Instr[3:0]),
    .iclass_o      (dec_cls),
    .alu_func_o    (dec_alu_func),
    .alu_bin_sel_o (dec_alu_bin_sel),
    .rf_b_sel_o    (dec_rf_b_sel),
    .illegal_o     (dec_illegal)
  );

  // Next-state, counters and pulse sources.
  always_comb begin
    state_d   = state_q;
    tmo_d     = '0;        // cleared everywhere except while still waiting in S_MEM
    retire    = 1'b0;
    illegal_d = 1'b0;
    mem_err_d = 1'b0;
    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_illegal) begin
          illegal_d = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (dec_cls)
          CLS_ALU:        state_d = S_WB;
          CLS_LW, CLS_SW: state_d = S_MEM;
          default: begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        // Ack is checked first so an ack on the timeout cycle still completes.
        if (Mem_Ack) begin
          if (dec_cls == CLS_LW) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (tmo_q == TMO_LAST) begin
          mem_err_d = 1'b1;
          state_d   = S_FETCH;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      tmo_q     <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Strobe decode from state and IR; Zero and Mem_Ack only steer the PC strobes.
  always_comb begin
    PC_Sel        = 1'b0;
    PC_LdEn       = 1'b0;
    IR_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = ALU_ADD;
    Mem_Req       = 1'b0;
    Mem_WrEn      = 1'b0;
    Illegal       = illegal_q;
    Mem_Err       = mem_err_q;
    case (state_q)
      S_FETCH: begin
        IR_LdEn = 1'b1;
      end
      S_DECODE: begin
        // Undefined opcode skips the instruction: PC advances by 4.
        PC_LdEn = dec_illegal;
      end
      S_EXEC: begin
        RF_B_sel    = dec_rf_b_sel;
        ALU_Bin_sel = dec_alu_bin_sel;
        ALU_func    = dec_alu_func;
        if (dec_cls inside {CLS_BEQ, CLS_BNE, CLS_B}) begin
          PC_LdEn = 1'b1;
          PC_Sel  = branch_taken(dec_cls, Zero);
        end
      end
      S_MEM: begin
        // Address generation stays selected for the whole access.
        RF_B_sel    = dec_rf_b_sel;
        ALU_Bin_sel = dec_alu_bin_sel;
        ALU_func    = dec_alu_func;
        Mem_Req     = 1'b1;
        Mem_WrEn    = (dec_cls == CLS_SW);
        // sw completes here on ack; a timeout also moves on to the next instruction.
        PC_LdEn     = (Mem_Ack && dec_cls == CLS_SW) || (!Mem_Ack && tmo_q == TMO_LAST);
      end
      S_WB: begin
        RF_B_sel      = dec_rf_b_sel;
        ALU_Bin_sel   = dec_alu_bin_sel;
        ALU_func      = dec_alu_func;
        RF_WrEn       = 1'b1;
        RF_WrData_sel = (dec_cls == CLS_LW);
        PC_LdEn       = 1'b1;
      end
      default: begin
        IR_LdEn = 1'b0;
      end
    endcase
    // Reset cancels any in-flight strobe in the same cycle, including Mem_Req.
    if (Reset) begin
      PC_Sel        = 1'b0;
      PC_LdEn       = 1'b0;
      IR_LdEn       = 1'b0;
      RF_WrEn       = 1'b0;
      RF_WrData_sel = 1'b0;
      RF_B_sel      = 1'b0;
      ALU_Bin_sel   = 1'b0;
      ALU_func      = 4'b0000;
      Mem_Req       = 1'b0;
      Mem_WrEn      = 1'b0;
      Illegal       = 1'b0;
      Mem_Err       = 1'b0;
    end
  end

  assign Retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Purpose: directed self-checking bench for multicycle_control with a per-cycle expected-output queue.
// Latency: one queue entry per clock cycle, compared at the falling edge.
// Backpressure: Mem_Ack driven by the bench per step.
// Ports: none.
module tb_multicycle_control;

  localparam int CW = 4;   // small counter so wrap-around is reachable

  logic          Clk = 1'b0;
  logic          Reset;
  logic [31:0]   Instr;
  logic          Zero;
  logic          Mem_Ack;
  logic          PC_Sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
  logic [3:0]    ALU_func;
  logic          Mem_Req, Mem_WrEn, Illegal, Mem_Err;
  logic [CW-1:0] Retired;

  always #5 Clk = ~Clk;

  multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Instr         (Instr),
    .Zero          (Zero),
    .Mem_Ack       (Mem_Ack),
    .PC_Sel        (PC_Sel),
    .PC_LdEn       (PC_LdEn),
    .IR_LdEn       (IR_LdEn),
    .RF_WrEn       (RF_WrEn),
    .RF_WrData_sel (RF_WrData_sel),
    .RF_B_sel      (RF_B_sel),
    .ALU_Bin_sel   (ALU_Bin_sel),
    .ALU_func      (ALU_func),
    .Mem_Req       (Mem_Req),
    .Mem_WrEn      (Mem_WrEn),
    .Illegal       (Illegal),
    .Mem_Err       (Mem_Err),
    .Retired       (Retired)
  );

  typedef struct packed {
    logic       pc_sel, pc_ld, ir_ld, rf_we, rf_wds, rf_bsel, alu_bsel;
    logic [3:0] alu_f;
    logic       mreq, mwe, ill, merr;
  } ov_t;

  typedef struct packed {
    ov_t           o;
    logic [CW-1:0] ret;
  } exp_t;

  ov_t obs;
  assign obs = {PC_Sel, PC_LdEn, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel,
                ALU_func, Mem_Req, Mem_WrEn, Illegal, Mem_Err};

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [CW-1:0] ret_m = '0;

  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0001;
  localparam logic [3:0] F_OR  = 4'b0011;

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [5:0] fn);
    return {op, 20'hA5C3E, fn};
  endfunction

  function automatic ov_t e_fetch(input logic ill, input logic merr);
    ov_t v = '0;
    v.ir_ld = 1'b1; v.ill = ill; v.merr = merr;
    return v;
  endfunction

  function automatic ov_t e_sel(input logic [3:0] f, input logic bs, input logic rb);
    ov_t v = '0;
    v.alu_f = f; v.alu_bsel = bs; v.rf_bsel = rb;
    return v;
  endfunction

  function automatic ov_t e_exec(input logic [3:0] f, input logic bs, input logic rb,
                                 input logic pcld, input logic pcsel);
    ov_t v = e_sel(f, bs, rb);
    v.pc_ld = pcld; v.pc_sel = pcsel;
    return v;
  endfunction

  function automatic ov_t e_mem(input logic [3:0] f, input logic bs, input logic rb,
                                input logic we, input logic pcld);
    ov_t v = e_sel(f, bs, rb);
    v.mreq = 1'b1; v.mwe = we; v.pc_ld = pcld;
    return v;
  endfunction

  function automatic ov_t e_wb(input logic [3:0] f, input logic bs, input logic rb, input logic wds);
    ov_t v = e_sel(f, bs, rb);
    v.rf_we = 1'b1; v.rf_wds = wds; v.pc_ld = 1'b1;
    return v;
  endfunction

  // One clock cycle: drive inputs, queue the expectation, compare at the falling edge,
  // then step past the rising edge and apply the expected retire.
  task automatic step(input logic ack, input logic zero, input ov_t e, input logic retire,
                      input string tag);
    exp_t x;
    Mem_Ack = ack;
    Zero    = zero;
    x.o     = e;
    x.ret   = ret_m;
    sb.push_back(x);
    @(negedge Clk);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      x = sb.pop_front();
      n_cmp++;
      assert (obs === x.o) else begin
        n_bad++;
        $error("FAIL %s strobes observed=%h expected=%h", tag, obs, x.o);
      end
      n_cmp++;
      assert (Retired === x.ret) else begin
        n_bad++;
        $error("FAIL %s retired observed=%0d expected=%0d", tag, Retired, x.ret);
      end
    end
    @(posedge Clk);
    #1;
    if (retire) ret_m = ret_m + 1'b1;
  endtask

  initial begin
    Reset   = 1'b1;
    Instr   = 32'h0;
    Zero    = 1'b0;
    Mem_Ack = 1'b0;

    // Reset held two cycles: every strobe low, counter clear.
    step(0, 0, '0, 0, "rst0");
    step(0, 0, '0, 0, "rst1");
    Reset = 1'b0;

    // addi
    Instr = ins(6'b110000, 6'b000000);
    step(0, 0, e_fetch(0, 0), 0, "addi_fetch");
    step(0, 0, '0, 0, "addi_dec");
    step(0, 0, e_exec(F_ADD, 1, 0, 0, 0), 0, "addi_exec");
    step(0, 0, e_wb(F_ADD, 1, 0, 0), 1, "addi_wb");

    // beq with Zero=1: taken
    Instr = ins(6'b000000, 6'b000000);
    step(0, 0, e_fetch(0, 0), 0, "beq_fetch");
    step(0, 0, '0, 0, "beq_dec");
    step(0, 1, e_exec(F_SUB, 0, 1, 1, 1), 1, "beq_exec");

    // bne with Zero=1: not taken
    Instr = ins(6'b000001, 6'b000000);
    step(0, 1, e_fetch(0, 0), 0, "bne_fetch");
    step(0, 1, '0, 0, "bne_dec");
    step(0, 1, e_exec(F_SUB, 0, 1, 1, 0), 1, "bne_exec");

    // unconditional b with Zero=0: taken
    Instr = ins(6'b111111, 6'b000000);
    step(0, 0, e_fetch(0, 0), 0, "b_fetch");
    step(0, 0, '0, 0, "b_dec");
    step(0, 0, e_exec(F_SUB, 0, 0, 1, 1), 1, "b_exec");

    // R-type or
    Instr = ins(6'b100000, 6'b000011);
    step(0, 0, e_fetch(0, 0), 0, "or_fetch");
    step(0, 0, '0, 0, "or_dec");
    step(0, 0, e_exec(F_OR, 0, 0, 0, 0), 0, "or_exec");
    step(0, 0, e_wb(F_OR, 0, 0, 0), 1, "or_wb");

    // lw, ack after 3 wait cycles (ack lands on the timeout cycle and must win)
    Instr = ins(6'b001111, 6'b000000);
    step(0, 0, e_fetch(0, 0), 0, "lw_fetch");
    step(0, 0, '0, 0, "lw_dec");
    step(0, 0, e_exec(F_ADD, 1, 0, 0, 0), 0, "lw_exec");
    for (int i = 0; i < 3; i++) step(0, 0, e_mem(F_ADD, 1, 0, 0, 0), 0, "lw_wait");
    step(1, 0, e_mem(F_ADD, 1, 0, 0, 0), 0, "lw_ack");
    step(0, 0, e_wb(F_ADD, 1, 0, 1), 1, "lw_wb");

    // sw with no ack: times out after 4 request cycles
    Instr = ins(6'b011111, 6'b000000);
    step(0, 0, e_fetch(0, 0), 0, "swt_fetch");
    step(0, 0, '0, 0, "swt_dec");
    step(0, 0, e_exec(F_ADD, 1, 1, 0, 0), 0, "swt_exec");
    for (int i = 0; i < 3; i++) step(0, 0, e_mem(F_ADD, 1, 1, 1, 0), 0, "swt_wait");
    step(0, 0, e_mem(F_ADD, 1, 1, 1, 1), 0, "swt_timeout");

    // sw again, ack after one wait; fetch shows the Mem_Err pulse from the abort
    step(0, 0, e_fetch(0, 1), 0, "sw_fetch_err");
    step(0, 0, '0, 0, "sw_dec");
    step(0, 0, e_exec(F_ADD, 1, 1, 0, 0), 0, "sw_exec");
    step(0, 0, e_mem(F_ADD, 1, 1, 1, 0), 0, "sw_wait");
    step(1, 0, e_mem(F_ADD, 1, 1, 1, 1), 1, "sw_ack");

    // undefined opcode
    Instr = ins(6'b101010, 6'b000000);
    step(0, 0, e_fetch(0, 0), 0, "ill_fetch");
    step(0, 0, e_exec(F_ADD, 0, 0, 1, 0), 0, "ill_dec");
    Instr = ins(6'b111111, 6'b000000);
    step(0, 0, e_fetch(1, 0), 0, "ill_pulse");
    step(0, 0, '0, 0, "b2_dec");
    step(0, 0, e_exec(F_SUB, 0, 0, 1, 1), 1, "b2_exec");

    // run branches until the 4-bit retired count wraps
    for (int i = 0; i < 10; i++) begin
      step(0, 0, e_fetch(0, 0), 0, "wrap_fetch");
      step(0, 0, '0, 0, "wrap_dec");
      step(0, 0, e_exec(F_SUB, 0, 0, 1, 1), 1, "wrap_exec");
    end

    // reset in the middle of a memory access, with an ack arriving that same cycle
    Instr = ins(6'b001111, 6'b000000);
    step(0, 0, e_fetch(0, 0), 0, "rmem_fetch");
    step(0, 0, '0, 0, "rmem_dec");
    step(0, 0, e_exec(F_ADD, 1, 0, 0, 0), 0, "rmem_exec");
    step(0, 0, e_mem(F_ADD, 1, 0, 0, 0), 0, "rmem_wait");
    Reset = 1'b1;
    step(1, 0, '0, 0, "rmem_reset");
    ret_m = '0;
    Reset = 1'b0;
    step(0, 0, e_fetch(0, 0), 0, "post_fetch");
    step(0, 0, '0, 0, "post_dec");
    step(0, 0, e_exec(F_ADD, 1, 0, 0, 0), 0, "post_exec");
    step(1, 0, e_mem(F_ADD, 1, 0, 0, 0), 0, "post_ack");
    step(0, 0, e_wb(F_ADD, 1, 0, 1), 1, "post_wb");
    step(0, 0, e_fetch(0, 0), 0, "post_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
